serial_code_conv: RTL
=====================

# serial_code_conv

Parametrised, bit-serial BCD/Excess-3 code converter for multi-digit words, successor to the single-digit Lab3 Excess-3-to-BCD state-diagram converter. Accepts one bit per enabled cycle, LSB-first per digit, least-significant digit first. Emits the converted bit combinationally in the same cycle (Mealy), as the single-digit converter does. Adds direction select, per-digit code checking and a parallel word output. Sits between the serial stimulus source and downstream BCD display/check logic.

## Interface
- DIGITS, 4, digits per word (1..8)
- Clk  in  1  clock, all state updates on posedge
- Rst  in  1  reset, synchronous, active-high
- En  in  1  X is a valid bit this cycle; low = stall, state held
- Mode  in  1  0 = Excess-3 → BCD (subtract 3), 1 = BCD → Excess-3 (add 3); sampled on first bit of word
- X  in  1  serial input bit
- Z  out  1  serial converted bit, combinational, valid when En=1
- DigitDone  out  1  registered one-cycle pulse after 4th bit of a digit
- DigitErr  out  1  registered, qualifies DigitDone: digit code was illegal
- WordDone  out  1  registered one-cycle pulse after last bit of last digit
- WordErr  out  1  registered, valid with WordDone: OR of all DigitErr in word
- Word  out  4*DIGITS  last completed converted word; Word[3:0] = digit 0

## Operation
- Per digit: Z = X ^ K[bit] ^ c; c_next = majority(X, K[bit], c); c cleared at every digit start, final carry discarded.
- K (LSB-first): Mode 0 → 1,0,1,1 (0b1101, two's complement of 3); Mode 1 → 1,1,0,0 (0b0011).
- Counters: bit_cnt 0..3, dig_cnt 0..DIGITS-1; advance only on En=1; wrap to 0 after final bit of final digit.
- Word-mode register: loaded from Mode when En=1 and bit_cnt=0 and dig_cnt=0; Mode changes mid-word ignored.
- Input digit captured in 3-bit shift register; legality evaluated on 4th bit: Mode 0 legal 3..12, Mode 1 legal 0..9.
- Illegal digit: Z still computed arithmetically (modulo 16); DigitErr=1 with DigitDone; sticks into word error.
- Z bits shifted into a 4*DIGITS staging register; Word loaded from staging (including final bit) when WordDone asserts; Word otherwise held.
- En=0: Z=0, no counter/carry/shift update.

## Timing
- Z: zero latency, same cycle as X.
- DigitDone/DigitErr: cycle after the 4th enabled bit's posedge, one cycle wide.
- WordDone/WordErr/Word: same cycle as final DigitDone.
- Back-to-back words: next word's first bit accepted the cycle after last bit; no dead cycle.
- Stall on any bit, including the last: pulses deferred until that bit is accepted.
- Reset: Z=0 (combinationally, because En ignored during Rst), DigitDone=0, DigitErr=0, WordDone=0, WordErr=0, Word=0, counters/carry/staging/mode=0. Rst dominates En; reset mid-word discards partial word, no pulses.

## Structure
- Package conv_pkg: DIGIT_W=4, K_SUB3=4'b1101, K_ADD3=4'b0011, XS3_MIN=3, XS3_MAX=12, BCD_MAX=9, mode constants MODE_XS3_TO_BCD=0, MODE_BCD_TO_XS3=1.
- Sub-module serial_digit_adder: one bit-serial adder (carry flop, clear-at-digit-start, constant addend bit in, sum out); top holds counters, legality check, staging and Word.

## Test plan
- Mode 0, DIGITS=1, Excess-3 inputs 3..12 streamed LSB-first -> Z bits give BCD 0..9, DigitErr=0, Word=input-3 each word.
- Mode 1, DIGITS=4, BCD 9,3,0,7 (digit 0 = 9) -> Word=0xA36C in hex nibble order (digit3..0 = A,3,6,C... i.e. 7+3=A, 0+3=3, 3+3=6, 9+3=C), WordDone once, WordErr=0.
- Mode 0, digit value 14 (illegal) in digit 1 of 4 -> DigitErr=1 on that DigitDone only, Z=1011, WordErr=1; next word clean -> WordErr=0.
- Random En stalls (including on 4th bit of last digit) -> Word/pulses identical to unstalled run, deferred by stall count.
- Rst asserted after 6 bits of a word -> all outputs 0 next cycle, no WordDone; fresh word then converts correctly.
- Mode toggled mid-word -> conversion uses mode latched on first bit; next word uses new mode.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants for the bit-serial BCD / Excess-3 converter.
// K_* are the per-digit addends, applied LSB-first.
package conv_pkg;
  localparam int          DIGIT_W         = 4;
  localparam logic [3:0]  K_SUB3          = 4'b1101;
  localparam logic [3:0]  K_ADD3          = 4'b0011;
  localparam int          XS3_MIN         = 3;
  localparam int          XS3_MAX         = 12;
  localparam int          BCD_MAX         = 9;
  localparam logic        MODE_XS3_TO_BCD = 1'b0;
  localparam logic        MODE_BCD_TO_XS3 = 1'b1;

  function automatic logic digit_legal(input logic mode, input logic [3:0] d);
    if (mode == MODE_BCD_TO_XS3) return d <= 4'(BCD_MAX);
    return (d >= 4'(XS3_MIN)) && (d <= 4'(XS3_MAX));
  endfunction
endpackage

// File: rtl/serial_digit_adder.sv
// One-bit serial adder with carry flop; Start forces carry-in to zero so each
// digit is added independently and the final carry of a digit is dropped.
module serial_digit_adder (
  input  logic Clk,
  input  logic Rst,
  input  logic En,
  input  logic Start,
  input  logic X,
  input  logic K,
  output logic Z
);
  logic carry;
  logic c_in;

  assign c_in = Start ? 1'b0 : carry;
  assign Z    = X ^ K ^ c_in;

  always_ff @(posedge Clk) begin
    if (Rst)     carry <= 1'b0;
    else if (En) carry <= (X & K) | (X & c_in) | (K & c_in);
  end
endmodule

// File: rtl/serial_code_conv.sv
// Multi-digit bit-serial Excess-3 <-> BCD converter with per-digit code
// checking and a parallel copy of the last completed converted word.
module serial_code_conv
  import conv_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      En,
  input  logic                      Mode,
  input  logic                      X,
  output logic                      Z,
  output logic                      DigitDone,
  output logic                      DigitErr,
  output logic                      WordDone,
  output logic                      WordErr,
  output logic [DIGIT_W*DIGITS-1:0] Word
);
  localparam int WORD_W = DIGIT_W * DIGITS;
  localparam int DC_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [1:0]        bit_cnt;
  logic [DC_W-1:0]   dig_cnt;
  logic              mode_q;
  logic [2:0]        in_sr;
  logic              err_acc;
  logic [WORD_W-1:0] stage;

  logic       accept, first_bit, last_bit, last_dig;
  logic       mode_eff, k_bit, sum, dig_err, err_word;
  logic [3:0] digit_in;

  assign accept    = En & ~Rst;
  assign first_bit = (bit_cnt == 2'd0) && (dig_cnt == '0);
  assign last_bit  = (bit_cnt == 2'd3);
  assign last_dig  = (dig_cnt == DC_W'(DIGITS - 1));
  // The first bit of a word must already convert with the new mode.
  assign mode_eff  = first_bit ? Mode : mode_q;
  assign k_bit     = (mode_eff == MODE_BCD_TO_XS3) ? K_ADD3[bit_cnt] : K_SUB3[bit_cnt];
  assign digit_in  = {X, in_sr};
  assign dig_err   = ~digit_legal(mode_eff, digit_in);
  assign err_word  = ((dig_cnt == '0) ? 1'b0 : err_acc) | dig_err;
  assign Z         = accept ? sum : 1'b0;

  serial_digit_adder u_adder (
    .Clk   (Clk),
    .Rst   (Rst),
    .En    (accept),
    .Start (bit_cnt == 2'd0),
    .X     (X),
    .K     (k_bit),
    .Z     (sum)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bit_cnt   <= '0;
      dig_cnt   <= '0;
      mode_q    <= MODE_XS3_TO_BCD;
      in_sr     <= '0;
      err_acc   <= 1'b0;
      stage     <= '0;
      Word      <= '0;
      DigitDone <= 1'b0;
      DigitErr  <= 1'b0;
      WordDone  <= 1'b0;
      WordErr   <= 1'b0;
    end else begin
      DigitDone <= 1'b0;
      DigitErr  <= 1'b0;
      WordDone  <= 1'b0;
      WordErr   <= 1'b0;
      if (En) begin
        stage   <= {sum, stage[WORD_W-1:1]};
        in_sr   <= {X, in_sr[2:1]};
        bit_cnt <= bit_cnt + 2'd1;
        if (first_bit) mode_q <= Mode;
        if (last_bit) begin
          DigitDone <= 1'b1;
          DigitErr  <= dig_err;
          if (last_dig) begin
            dig_cnt  <= '0;
            err_acc  <= 1'b0;
            WordDone <= 1'b1;
            WordErr  <= err_word;
            Word     <= {sum, stage[WORD_W-1:1]};
          end else begin
            dig_cnt <= dig_cnt + DC_W'(1);
            err_acc <= err_word;
          end
        end
      end
    end
  end
endmodule
